// File: rtl/solitaire_pkg.sv
// Shared solitaire definitions: card field layout, rank limits, command codes and column states.
package solitaire_pkg;

   localparam int RANK_LSB = 0;
   localparam int RANK_MSB = 3;
   localparam int SUIT_LSB = 4;

   localparam logic [3:0] RANK_ACE  = 4'd1;
   localparam logic [3:0] RANK_KING = 4'd13;

   // EMPTY is all-ones at whatever card width a module uses; slice from the low end.
   localparam logic [63:0] EMPTY_FILL = '1;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'b000,
      CMD_POP   = 3'b001,
      CMD_PUSH  = 3'b010,
      CMD_START = 3'b100,
      CMD_CLEAR = 3'b111
   } cmd_e;

   typedef enum logic {
      ST_LOAD,
      ST_PLAY
   } state_e;

   function automatic logic rank_valid(input logic [3:0] rank);
      return (rank >= RANK_ACE) && (rank <= RANK_KING);
   endfunction

endpackage

// File: rtl/tableau_rule_check.sv
// Combinational build-rule check for a play push: descending rank, alternating colour, king on empty.
module tableau_rule_check
   import solitaire_pkg::*;
#(
   parameter int CARD_W = 6,
   parameter int RULES  = 1
) (
   input  logic [CARD_W-1:0] top_card,
   input  logic              top_valid,
   input  logic [CARD_W-1:0] card_in,
   output logic              legal
);

   logic [3:0] top_rank;
   logic [3:0] in_rank;
   logic       build_ok;

   always_comb begin
      top_rank = top_card[RANK_MSB:RANK_LSB];
      in_rank  = card_in[RANK_MSB:RANK_LSB];
      if (!top_valid) begin
         build_ok = (in_rank == RANK_KING);
      end else begin
         build_ok = (top_rank == in_rank + 4'd1) &&
                    (top_card[CARD_W-1] != card_in[CARD_W-1]);
      end
      // A malformed rank is never legal, even with build rules switched off.
      legal = rank_valid(in_rank) && ((RULES == 0) || build_ok);
   end

endmodule

// File: rtl/tableau_column.sv
// One solitaire tableau column: LIFO card stack with a face-down/face-up boundary and LOAD/PLAY modes.
module tableau_column
   import solitaire_pkg::*;
#(
   parameter int DEPTH  = 19,
   parameter int CARD_W = 6,
   parameter int RULES  = 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CARD_W-1:0] card_in,
   input  logic [2:0]        cmd,
   output logic [CARD_W-1:0] value_out,
   output logic              ack,
   output logic              err,
   output logic [CARD_W-1:0] top_card,
   output logic              top_up,
   output logic [CNT_W-1:0]  count,
   output logic [CNT_W-1:0]  down_count,
   output logic              empty,
   output logic              full,
   output logic              play_mode
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CARD_W-1:0] EMPTY   = EMPTY_FILL[CARD_W-1:0];
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    down_q, down_d;
   logic [CARD_W-1:0]   value_q, value_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;

   logic [CARD_W-1:0]   mem [DEPTH];
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    top_idx;
   logic                non_empty;
   logic                is_full;
   logic                push_legal;

   assign non_empty = (count_q != '0);
   assign is_full   = (count_q == DEPTH_C);
   assign wr_idx    = IDX_W'(count_q);
   assign top_idx   = IDX_W'(count_q - ONE);

   assign top_card   = non_empty ? mem[top_idx] : EMPTY;
   assign top_up     = non_empty && (down_q < count_q);
   assign count      = count_q;
   assign down_count = down_q;
   assign empty      = !non_empty;
   assign full       = is_full;
   assign play_mode  = (state_q == ST_PLAY);
   assign value_out  = value_q;
   assign ack        = ack_q;
   assign err        = err_q;

   tableau_rule_check #(
      .CARD_W (CARD_W),
      .RULES  (RULES)
   ) u_rule_check (
      .top_card  (top_card),
      .top_valid (non_empty),
      .card_in   (card_in),
      .legal     (push_legal)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d = state_q;
      count_d = count_q;
      down_d  = down_q;
      value_d = EMPTY;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      case (cmd)
         CMD_NOP: ;
         CMD_POP: begin
            if (state_q == ST_PLAY && non_empty) begin
               value_d = top_card;
               count_d = count_q - ONE;
               ack_d   = 1'b1;
               // The card beneath becomes the top; flip it if it was face-down.
               if (down_q == count_d && count_d != '0) begin
                  down_d = down_q - ONE;
               end
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_PUSH: begin
            if (is_full) begin
               err_d = 1'b1;
            end else if (state_q == ST_LOAD) begin
               if (rank_valid(card_in[RANK_MSB:RANK_LSB])) begin
                  wr_en   = 1'b1;
                  count_d = count_q + ONE;
                  down_d  = down_q + ONE;
                  ack_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (push_legal) begin
               wr_en   = 1'b1;
               count_d = count_q + ONE;
               ack_d   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_START: begin
            if (state_q == ST_LOAD) begin
               state_d = ST_PLAY;
               ack_d   = 1'b1;
               if (non_empty) begin
                  down_d = count_q - ONE;
               end
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_CLEAR: begin
            state_d = ST_LOAD;
            count_d = '0;
            down_d  = '0;
            ack_d   = 1'b1;
         end
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         count_q <= '0;
         down_q  <= '0;
         value_q <= EMPTY;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         down_q  <= down_d;
         value_q <= value_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // NOTE: card storage has no reset; slots at or above count are never read out.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= card_in;
      end
   end

endmodule

// File: tb/tb_tableau_column.sv
// Directed bench for tableau_column: default-depth play sequence plus a DEPTH=4 capacity/reset column.
module tb_tableau_column;
   import solitaire_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic [5:0] card_a, value_a, top_a;
   logic [2:0] cmd_a;
   logic       ack_a, err_a, top_up_a, empty_a, full_a, play_a;
   logic [4:0] count_a, down_a;

   logic [5:0] card_b, value_b, top_b;
   logic [2:0] cmd_b;
   logic       ack_b, err_b, top_up_b, empty_b, full_b, play_b;
   logic [2:0] count_b, down_b;

   int checks = 0;
   int errors = 0;

   tableau_column dut (
      .clk        (clk),
      .rst        (rst),
      .card_in    (card_a),
      .cmd        (cmd_a),
      .value_out  (value_a),
      .ack        (ack_a),
      .err        (err_a),
      .top_card   (top_a),
      .top_up     (top_up_a),
      .count      (count_a),
      .down_count (down_a),
      .empty      (empty_a),
      .full       (full_a),
      .play_mode  (play_a)
   );

   tableau_column #(.DEPTH(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .card_in    (card_b),
      .cmd        (cmd_b),
      .value_out  (value_b),
      .ack        (ack_b),
      .err        (err_b),
      .top_card   (top_b),
      .top_up     (top_up_b),
      .count      (count_b),
      .down_count (down_b),
      .empty      (empty_b),
      .full       (full_b),
      .play_mode  (play_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_a(input logic [2:0] c, input logic [5:0] card);
      @(negedge clk);
      cmd_a  = c;
      card_a = card;
      @(posedge clk);
      #1;
      cmd_a = CMD_NOP;
   endtask

   task automatic step_b(input logic [2:0] c, input logic [5:0] card);
      @(negedge clk);
      cmd_b  = c;
      card_b = card;
      @(posedge clk);
      #1;
      cmd_b = CMD_NOP;
   endtask

   initial begin
      rst    = 1'b1;
      cmd_a  = CMD_NOP;
      card_a = '0;
      cmd_b  = CMD_NOP;
      card_b = '0;
      #12;
      check("rst_count",  count_a, 0);
      check("rst_down",   down_a, 0);
      check("rst_empty",  empty_a, 1);
      check("rst_full",   full_a, 0);
      check("rst_top",    top_a, 6'h3F);
      check("rst_value",  value_a, 6'h3F);
      check("rst_play",   play_a, 0);
      check("rst_ackerr", {ack_a, err_a}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      // Load two face-down cards and start play.
      step_a(CMD_PUSH, 6'h27);
      check("load1_ack",   ack_a, 1);
      check("load1_count", count_a, 1);
      check("load1_down",  down_a, 1);
      check("load1_top",   top_a, 6'h27);
      check("load1_up",    top_up_a, 0);
      step_a(CMD_PUSH, 6'h35);
      check("load2_count", count_a, 2);
      check("load2_down",  down_a, 2);
      step_a(CMD_START, 6'h00);
      check("start_ack",   ack_a, 1);
      check("start_count", count_a, 2);
      check("start_down",  down_a, 1);
      check("start_top",   top_a, 6'h35);
      check("start_up",    top_up_a, 1);
      check("start_play",  play_a, 1);

      // Build down in alternating colours.
      step_a(CMD_PUSH, 6'h04);
      check("red4_ack",    ack_a, 1);
      check("red4_count",  count_a, 3);
      step_a(CMD_PUSH, 6'h33);
      check("blk3_ack",    ack_a, 1);
      check("blk3_count",  count_a, 4);
      step_a(CMD_PUSH, 6'h23);
      check("bad3_err",    {ack_a, err_a}, 2'b01);
      check("bad3_count",  count_a, 4);
      check("bad3_top",    top_a, 6'h33);

      // Pop back down to the face-down card, which must flip.
      step_a(CMD_POP, 6'h00);
      check("pop1_value",  value_a, 6'h33);
      check("pop1_count",  count_a, 3);
      step_a(CMD_POP, 6'h00);
      check("pop2_value",  value_a, 6'h04);
      step_a(CMD_POP, 6'h00);
      check("pop3_value",  value_a, 6'h35);
      check("pop3_count",  count_a, 1);
      check("pop3_down",   down_a, 0);
      check("pop3_top",    top_a, 6'h27);
      check("pop3_up",     top_up_a, 1);
      step_a(CMD_START, 6'h00);
      check("start_play_err", {ack_a, err_a, value_a}, {2'b01, 6'h3F});
      step_a(CMD_POP, 6'h00);
      check("pop4_value",  value_a, 6'h27);
      check("pop4_empty",  empty_a, 1);

      // Empty play column accepts only a king.
      step_a(CMD_PUSH, 6'h0C);
      check("queen_err",   err_a, 1);
      check("queen_count", count_a, 0);
      step_a(CMD_PUSH, 6'h0D);
      check("king_ack",    ack_a, 1);
      check("king_top",    top_a, 6'h0D);
      step_a(CMD_POP, 6'h00);
      check("king_pop",    value_a, 6'h0D);
      step_a(CMD_POP, 6'h00);
      check("empty_pop",   {ack_a, err_a, value_a}, {2'b01, 6'h3F});
      step_a(CMD_PUSH, 6'h00);
      check("rank0_err",   err_a, 1);
      step_a(3'b011, 6'h00);
      check("illegal_err", {ack_a, err_a}, 2'b01);
      step_a(CMD_NOP, 6'h00);
      check("nop_quiet",   {ack_a, err_a}, 2'b00);
      step_a(CMD_PUSH, 6'h0D);
      step_a(CMD_CLEAR, 6'h00);
      check("clear_ack",   ack_a, 1);
      check("clear_state", {play_a, count_a, empty_a}, {1'b0, 5'd0, 1'b1});

      // Small column: capacity and rank limits in LOAD.
      step_b(CMD_PUSH, 6'h01);
      step_b(CMD_PUSH, 6'h22);
      step_b(CMD_PUSH, 6'h13);
      check("d4_count3",   count_b, 3);
      step_b(CMD_PUSH, 6'h3F);
      check("d4_rankF",    {ack_b, err_b}, 2'b01);
      check("d4_rankF_cnt", count_b, 3);
      step_b(CMD_PUSH, 6'h04);
      check("d4_full",     full_b, 1);
      check("d4_top",      top_b, 6'h04);
      check("d4_up",       top_up_b, 0);
      step_b(CMD_PUSH, 6'h05);
      check("d4_over_err", err_b, 1);
      check("d4_over_cnt", count_b, 4);
      step_b(CMD_POP, 6'h00);
      check("d4_loadpop",  {err_b, value_b, count_b}, {1'b1, 6'h3F, 3'd4});

      // Reset in the middle of an offered push.
      @(negedge clk);
      cmd_b  = CMD_PUSH;
      card_b = 6'h06;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_async", {count_b, down_b, full_b, empty_b, top_b},
            {3'd0, 3'd0, 1'b0, 1'b1, 6'h3F});
      @(posedge clk);
      #1;
      check("mid_rst_outs", {value_b, ack_b, err_b, top_up_b, play_b, count_b},
            {6'h3F, 4'b0000, 3'd0});
      @(negedge clk);
      rst   = 1'b0;
      cmd_b = CMD_NOP;
      step_b(CMD_PUSH, 6'h07);
      check("post_rst_push", {ack_b, count_b, top_b}, {1'b1, 3'd1, 6'h07});
      check("post_rst_main", count_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
